// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory address/data pair plus the
// valid/ready issue channel between the fetch sequencer and the execute stage.
interface fetch_sequencer_if #(
    parameter int PC_WIDTH = 8,
    parameter int IRWidth  = 16
);
    logic [PC_WIDTH-1:0] pc;
    logic [IRWidth-1:0]  ir;
    logic [IRWidth-1:0]  instr;
    logic [PC_WIDTH-1:0] instr_pc;
    logic                instr_valid;
    logic                instr_ready;

    // Sequencer side: drives the memory address and the issue channel.
    modport master (
        output pc,
        input  ir,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    // Memory / execute side.
    modport slave (
        input  pc,
        output ir,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch controller. Resolves goto
// (opcode 4'b1000) internally and issues every other instruction to the
// execute stage over a valid/ready handshake. Supports run / single-step,
// external jumps (pended while an instruction is being handed over) and a
// sticky out-of-range target flag.
// Optional: define FETCH_SEQ_SELF_LOOP_HALT_EN to make a goto that targets its
// own address park the sequencer in HALT until an external jump.
module fetch_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int IRWidth  = 16,
    parameter int CMD_CNT  = 64
) (
    input  logic                clk,
    input  logic                res,
    input  logic                run,
    input  logic                step,
    input  logic                ext_jump,
    input  logic [PC_WIDTH-1:0] ext_target,
    fetch_sequencer_if.master   bus,
    output logic                halted,
    output logic                addr_err
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
`ifdef FETCH_SEQ_SELF_LOOP_HALT_EN
        , S_HALT = 2'd3
`endif
    } state_t;

    localparam logic [3:0]          OP_GOTO = 4'b1000;
    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(CMD_CNT - 1);

    state_t              state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic [IRWidth-1:0]  instr_reg, instr_next;
    logic [PC_WIDTH-1:0] instr_pc_reg, instr_pc_next;
    logic                instr_valid_reg, instr_valid_next;
    logic                addr_err_reg, addr_err_next;
    logic                jump_pend_reg, jump_pend_next;
    logic [PC_WIDTH-1:0] pend_target_reg, pend_target_next;

    logic                is_goto;
    logic [PC_WIDTH-1:0] goto_target;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                take_jump;
    logic [PC_WIDTH-1:0] load_tgt;
    logic                load_ok;
    logic [PC_WIDTH-1:0] load_pc;

    assign is_goto     = (bus.ir[IRWidth-1 -: 4] == OP_GOTO);
    assign goto_target = bus.ir[PC_WIDTH-1:0];
    assign pc_inc      = (pc_reg == LAST_PC) ? '0 : pc_reg + PC_WIDTH'(1);

    // A fresh ext_jump beats an older pended target; otherwise the load source is the goto.
    assign take_jump = ext_jump | jump_pend_reg;
    assign load_tgt  = take_jump ? (ext_jump ? ext_target : pend_target_reg) : goto_target;
    assign load_ok   = (32'(load_tgt) < 32'(CMD_CNT));
    assign load_pc   = load_ok ? load_tgt : '0;

    // State register; reset wins over everything, including an open handshake.
    always_ff @(posedge clk) begin
        if (res) begin
            state_reg       <= S_IDLE;
            pc_reg          <= '0;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
            addr_err_reg    <= 1'b0;
            jump_pend_reg   <= 1'b0;
            pend_target_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            instr_valid_reg <= instr_valid_next;
            addr_err_reg    <= addr_err_next;
            jump_pend_reg   <= jump_pend_next;
            pend_target_reg <= pend_target_next;
        end
    end

    // Next-state and datapath updates for the fetch/issue sequence.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        instr_valid_next = instr_valid_reg;
        addr_err_next    = addr_err_reg;
        jump_pend_next   = jump_pend_reg;
        pend_target_next = pend_target_reg;

        case (state_reg)
            S_IDLE: begin
                if (take_jump) begin
                    pc_next        = load_pc;
                    addr_err_next  = addr_err_reg | ~load_ok;
                    jump_pend_next = 1'b0;
                end else if (run || step) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (take_jump) begin
                    pc_next        = load_pc;
                    addr_err_next  = addr_err_reg | ~load_ok;
                    jump_pend_next = 1'b0;
                    state_next     = run ? S_FETCH : S_IDLE;
                end else if (is_goto) begin
`ifdef FETCH_SEQ_SELF_LOOP_HALT_EN
                    if (goto_target == pc_reg) begin
                        state_next = S_HALT;
                    end else begin
                        pc_next       = load_pc;
                        addr_err_next = addr_err_reg | ~load_ok;
                        state_next    = run ? S_FETCH : S_IDLE;
                    end
`else
                    pc_next       = load_pc;
                    addr_err_next = addr_err_reg | ~load_ok;
                    state_next    = run ? S_FETCH : S_IDLE;
`endif
                end else begin
                    instr_next       = bus.ir;
                    instr_pc_next    = pc_reg;
                    instr_valid_next = 1'b1;
                    pc_next          = pc_inc;
                    state_next       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Jumps arriving mid-handshake are remembered, never applied here.
                if (ext_jump) begin
                    jump_pend_next   = 1'b1;
                    pend_target_next = ext_target;
                end
                if (bus.instr_ready) begin
                    instr_valid_next = 1'b0;
                    state_next       = run ? S_FETCH : S_IDLE;
                end
            end
`ifdef FETCH_SEQ_SELF_LOOP_HALT_EN
            S_HALT: begin
                if (ext_jump) begin
                    pc_next       = load_pc;
                    addr_err_next = addr_err_reg | ~load_ok;
                    state_next    = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.pc          = pc_reg;
    assign bus.instr       = instr_reg;
    assign bus.instr_pc    = instr_pc_reg;
    assign bus.instr_valid = instr_valid_reg;
    assign addr_err        = addr_err_reg;

`ifdef FETCH_SEQ_SELF_LOOP_HALT_EN
    assign halted = (state_reg == S_HALT);
`else
    assign halted = 1'b0;
`endif
endmodule
